// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package data_mem_pkg;

  localparam int WORD_W = 32;

  // One bit per error cause, kept separate so a status register can report them.
  typedef struct packed {
    logic conflict;
    logic range;
    logic misalign;
  } err_cause_t;

  // Byte address is not word aligned.
  function automatic logic addr_misaligned(input logic [WORD_W-1:0] a);
    return a[1:0] != 2'b00;
  endfunction

  // Any address bit above the word-index field is set.
  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] a, input int aw);
    return (a >> (aw + 2)) != '0;
  endfunction

  // Byte address to word index; the caller truncates to its index width.
  function automatic logic [WORD_W-1:0] addr_word(input logic [WORD_W-1:0] a);
    return a >> 2;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Execute-stage to data-memory request/response bundle.
interface data_mem_responder_if;
  import data_mem_pkg::*;

  logic              memoryRead;
  logic              memoryWrite;
  logic [WORD_W-1:0] memoryAddressOut;
  logic [WORD_W-1:0] memoryDataOut;
  logic [WORD_W-1:0] memoryDataIn;
  logic              memReady;
  logic              memError;
  logic              errSticky;
  logic              wbEmpty;

  modport master (
    output memoryRead, memoryWrite, memoryAddressOut, memoryDataOut,
    input  memoryDataIn, memReady, memError, errSticky, wbEmpty
  );

  modport slave (
    input  memoryRead, memoryWrite, memoryAddressOut, memoryDataOut,
    output memoryDataIn, memReady, memError, errSticky, wbEmpty
  );

endinterface

// File: rtl/data_mem_responder_wb_fifo.sv
// Posted-write buffer: circular FIFO of {index, data} with a
// youngest-match lookup port for store-to-load forwarding.
module wb_fifo
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [IDX_W-1:0]  push_idx_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [IDX_W-1:0]  head_idx_o,
  output logic [WORD_W-1:0] head_data_o,
  input  logic [IDX_W-1:0]  lkp_idx_i,
  output logic              lkp_hit_o,
  output logic [WORD_W-1:0] lkp_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q;
  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [WORD_W-1:0] data_q [DEPTH];

  assign full_o      = count_q == CNT_W'(DEPTH);
  assign empty_o     = count_q == '0;
  assign head_idx_o  = idx_q[head_q];
  assign head_data_o = data_q[head_q];

  // Pointer/count next state; pointers wrap naturally at a power-of-two depth.
  always_comb begin
    head_d  = pop_i  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_i ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Control state; reset discards every pending store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Clear before set so a full-buffer push onto the draining slot stays valid.
      if (pop_i)  vld_q[head_q] <= 1'b0;
      if (push_i) vld_q[tail_q] <= 1'b1;
    end
  end

  // Entry payload needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (push_i) begin
      idx_q[tail_q]  <= push_idx_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Walk oldest to newest so the last match (the youngest store) wins.
  always_comb begin
    logic [PTR_W-1:0] p;
    p          = '0;
    lkp_hit_o  = 1'b0;
    lkp_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && vld_q[p] && idx_q[p] == lkp_idx_i) begin
        lkp_hit_o  = 1'b1;
        lkp_data_o = data_q[p];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: request decode, single-port word RAM and a
// posted-write buffer that drains whenever the RAM port is free.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WB_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_responder_if.slave bus
);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  rd, wr, req;
  err_cause_t            cause;
  logic                  err;
  logic                  drain, push, ready;
  logic                  wb_full, wb_empty;
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [WORD_W-1:0]     head_data;
  logic                  fwd_hit;
  logic [WORD_W-1:0]     fwd_data;
  logic                  err_sticky_q, err_sticky_d;
  logic [WORD_W-1:0]     ram_q [2**ADDR_WIDTH];

  assign rd  = bus.memoryRead;
  assign wr  = bus.memoryWrite;
  assign req = rd | wr;
  assign idx = ADDR_WIDTH'(addr_word(bus.memoryAddressOut));

  assign cause.misalign = req & addr_misaligned(bus.memoryAddressOut);
  assign cause.range    = req & addr_out_of_range(bus.memoryAddressOut, ADDR_WIDTH);
  assign cause.conflict = rd & wr;
  assign err            = |cause;

  // The RAM has one port, so any load (even a faulty one) owns it this cycle.
  assign drain = !wb_empty && !rd;
  // Stall term only bites for full + write + read; kept for a future dual-issue port.
  assign ready = !(wb_full && wr && !drain);
  assign push  = wr && !err && ready;

  wb_fifo #(
    .DEPTH (WB_DEPTH),
    .IDX_W (ADDR_WIDTH)
  ) u_wb (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_idx_i  (idx),
    .push_data_i (bus.memoryDataOut),
    .pop_i       (drain),
    .head_idx_o  (head_idx),
    .head_data_o (head_data),
    .lkp_idx_i   (idx),
    .lkp_hit_o   (fwd_hit),
    .lkp_data_o  (fwd_data),
    .full_o      (wb_full),
    .empty_o     (wb_empty)
  );

  // Retire the buffer head into the RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain) ram_q[head_idx] <= head_data;
  end

  // Zero-latency load data: buffered store first, then RAM; zero otherwise.
  always_comb begin
    bus.memoryDataIn = '0;
    if (rd && !err) bus.memoryDataIn = fwd_hit ? fwd_data : ram_q[idx];
  end

  assign err_sticky_d = err_sticky_q | err;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_sticky_q <= 1'b0;
    else      err_sticky_q <= err_sticky_d;
  end

  assign bus.memReady  = ready;
  assign bus.memError  = err;
  assign bus.errSticky = err_sticky_q;
  assign bus.wbEmpty   = wb_empty;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with hand-computed expectations.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(
    .ADDR_WIDTH (10),
    .WB_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Drive one request cycle just after the falling edge; outputs settle by #1.
  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.memoryRead       = r;
    bus.memoryWrite      = w;
    bus.memoryAddressOut = a;
    bus.memoryDataOut    = d;
    #1;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] addrs [5];
  logic [31:0] datas [5];

  initial begin
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14};
    datas = '{32'hA0, 32'hA4, 32'hA8, 32'hAC, 32'hB4};

    rst                  = 1'b0;
    bus.memoryRead       = 1'b0;
    bus.memoryWrite      = 1'b0;
    bus.memoryAddressOut = '0;
    bus.memoryDataOut    = '0;
    #12;
    chk("rst_wbEmpty",   {31'b0, bus.wbEmpty},   32'd1);
    chk("rst_memReady",  {31'b0, bus.memReady},  32'd1);
    chk("rst_dataIn",    bus.memoryDataIn,       32'h0);
    chk("rst_errSticky", {31'b0, bus.errSticky}, 32'd0);
    chk("rst_memError",  {31'b0, bus.memError},  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Store then a single idle cycle drains it.
    req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("st10_ready", {31'b0, bus.memReady}, 32'd1);
    chk("st10_err",   {31'b0, bus.memError}, 32'd0);
    idle();
    chk("st10_pending", {31'b0, bus.wbEmpty}, 32'd0);
    chk("idle_dataIn",  bus.memoryDataIn,      32'h0);
    chk("idle_ready",   {31'b0, bus.memReady}, 32'd1);
    idle();
    chk("st10_drained", {31'b0, bus.wbEmpty}, 32'd1);
    req(1'b1, 1'b0, 32'h10, 32'h0);
    chk("ld10", bus.memoryDataIn, 32'hDEADBEEF);

    // Back-to-back stores to one word, load forwards the newest.
    req(1'b0, 1'b1, 32'h20, 32'h11);
    req(1'b0, 1'b1, 32'h20, 32'h22);
    req(1'b1, 1'b0, 32'h20, 32'h0);
    chk("ld20_fwd", bus.memoryDataIn, 32'h22);
    idle();
    idle();
    chk("st20_drained", {31'b0, bus.wbEmpty}, 32'd1);
    req(1'b1, 1'b0, 32'h20, 32'h0);
    chk("ld20_ram", bus.memoryDataIn, 32'h22);

    // Stores interleaved with loads holding the RAM port, then a fifth store.
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b1, addrs[i], datas[i]);
      req(1'b1, 1'b0, 32'h40, 32'h0);
    end
    req(1'b0, 1'b1, addrs[4], datas[4]);
    chk("st5_ready", {31'b0, bus.memReady}, 32'd1);
    idle();
    idle();
    chk("st5_drained", {31'b0, bus.wbEmpty}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      req(1'b1, 1'b0, addrs[i], 32'h0);
      chk($sformatf("ld_seq%0d", i), bus.memoryDataIn, datas[i]);
    end

    // Misaligned load and out-of-range store.
    req(1'b1, 1'b0, 32'h13, 32'h0);
    chk("mis_err",   {31'b0, bus.memError}, 32'd1);
    chk("mis_data",  bus.memoryDataIn,      32'h0);
    chk("mis_ready", {31'b0, bus.memReady}, 32'd1);
    idle();
    chk("sticky_set", {31'b0, bus.errSticky}, 32'd1);
    chk("idle_err",   {31'b0, bus.memError},  32'd0);
    req(1'b0, 1'b1, 32'h0000_1000, 32'hBAD0BAD0);
    chk("oor_err", {31'b0, bus.memError}, 32'd1);
    idle();
    chk("oor_wbEmpty", {31'b0, bus.wbEmpty}, 32'd1);
    req(1'b1, 1'b0, 32'h00, 32'h0);
    chk("oor_noalias", bus.memoryDataIn, 32'hA0);

    // Read+write conflict: flagged, nothing enqueued.
    req(1'b1, 1'b1, 32'h08, 32'h1234);
    chk("cfl_err",  {31'b0, bus.memError}, 32'd1);
    chk("cfl_data", bus.memoryDataIn,      32'h0);
    idle();
    chk("cfl_wbEmpty", {31'b0, bus.wbEmpty}, 32'd1);
    req(1'b1, 1'b0, 32'h08, 32'h0);
    chk("cfl_ld08", bus.memoryDataIn, 32'hA8);

    // Reset while a store is still buffered: it is lost, RAM keeps the old word.
    req(1'b0, 1'b1, 32'h30, 32'h5555);
    idle();
    idle();
    req(1'b0, 1'b1, 32'h30, 32'hAAAA);
    @(negedge clk);
    bus.memoryWrite = 1'b0;
    bus.memoryDataOut = '0;
    chk("pre_rst_pending", {31'b0, bus.wbEmpty}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_wbEmpty",   {31'b0, bus.wbEmpty},   32'd1);
    chk("midrst_errSticky", {31'b0, bus.errSticky}, 32'd0);
    chk("midrst_ready",     {31'b0, bus.memReady},  32'd1);
    @(negedge clk);
    rst = 1'b1;
    req(1'b1, 1'b0, 32'h30, 32'h0);
    chk("ld30_old", bus.memoryDataIn, 32'h5555);

    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
